// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: turns debounced pushbutton presses into single operation
// issues on the combinational 4-bit calculator. Each issue latches the
// operands, holds them for a settle window, then captures the result and
// overflow. Accumulate mode feeds the held result back as operand A.
// state_o mirrors the FSM state register so checkers can observe it.
module calc_op_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic [2:0] KEY,
    input  logic [7:0] SW,
    input  logic       ACC,
    output logic [2:0] calc_op,
    output logic [3:0] calc_A,
    output logic [3:0] calc_B,
    input  logic [3:0] calc_R,
    input  logic       calc_ovf,
    output logic [3:0] R_out,
    output logic       ovf_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] op_count,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // The settle counter counts down to zero, so it is loaded with one less
    // than the number of hold cycles.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [2:0] key_meta_q, key_sync_q, key_prev_q;
    logic [2:0] press;
    logic [2:0] win_op;

    state_t     state_q, state_d;
    logic [3:0] settle_q, settle_d;
    logic [2:0] op_q, op_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] r_q, r_d;
    logic       ovf_q, ovf_d;
    logic       done_q, done_d;
    logic [3:0] cnt_q, cnt_d;

    // Two-flop synchronizer plus previous-value register; reset loads
    // "pressed" so a key held through reset never produces an edge.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            key_meta_q <= 3'b000;
            key_sync_q <= 3'b000;
            key_prev_q <= 3'b000;
        end else begin
            key_meta_q <= KEY;
            key_sync_q <= key_meta_q;
            key_prev_q <= key_sync_q;
        end
    end

    // A press is a falling edge of the synchronized key; lowest index wins.
    always_comb begin
        press = key_prev_q & ~key_sync_q;
        if (press[0])      win_op = 3'b110;
        else if (press[1]) win_op = 3'b101;
        else               win_op = 3'b011;
    end

    // Next-state and datapath-load decisions for the IDLE/ISSUE/HOLD sequencer.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|press) begin
                    state_d  = ST_ISSUE;
                    op_d     = win_op;
                    a_d      = ACC ? r_q : SW[7:4];
                    b_d      = SW[3:0];
                    settle_d = SETTLE_LOAD;
                    // Leaving accumulate mode starts a fresh overflow chain.
                    if (!ACC) begin
                        ovf_d = 1'b0;
                    end
                end
            end
            ST_ISSUE: begin
                if (settle_q == 4'd0) begin
                    r_d     = calc_R;
                    ovf_d   = ovf_q | calc_ovf;
                    cnt_d   = cnt_q + 4'd1;
                    done_d  = 1'b1;
                    op_d    = 3'b111;
                    state_d = ST_HOLD;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            ST_HOLD: begin
                // Presses here are dropped; only a full release re-arms.
                if (&key_sync_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            settle_q <= 4'd0;
            op_q     <= 3'b111;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            r_q      <= 4'd0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    assign calc_op  = op_q;
    assign calc_A   = a_q;
    assign calc_B   = b_q;
    assign R_out    = r_q;
    assign ovf_out  = ovf_q;
    assign done     = done_q;
    assign op_count = cnt_q;
    assign busy     = (state_q != ST_IDLE);
    assign state_o  = state_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Testbench for calc_op_sequencer. Three instances share the same stimulus:
// index 0 uses SETTLE_CYCLES=2 and is scoreboarded, indices 1 and 2 use 1 and
// 15 for latency checks. Each instance gets its own adder stub.
module tb_calc_op_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst;
    logic [2:0] key;
    logic [7:0] sw;
    logic       acc;

    logic [2:0] c_op   [3];
    logic [3:0] c_a    [3];
    logic [3:0] c_b    [3];
    logic [3:0] c_r    [3];
    logic       c_v    [3];
    logic [3:0] r_out  [3];
    logic       ovf_o  [3];
    logic       busy   [3];
    logic       done   [3];
    logic [3:0] cnt    [3];
    logic [1:0] st     [3];

    // Calculator stub: 4-bit wrap add with signed overflow.
    for (genvar g = 0; g < 3; g++) begin : g_stub
        assign c_r[g] = c_a[g] + c_b[g];
        assign c_v[g] = (c_a[g][3] == c_b[g][3]) && (c_r[g][3] != c_a[g][3]);
    end

    calc_op_sequencer #(.SETTLE_CYCLES(2)) dut2 (
        .CLOCK_50(clk), .Reset(rst), .KEY(key), .SW(sw), .ACC(acc),
        .calc_op(c_op[0]), .calc_A(c_a[0]), .calc_B(c_b[0]),
        .calc_R(c_r[0]), .calc_ovf(c_v[0]), .R_out(r_out[0]),
        .ovf_out(ovf_o[0]), .busy(busy[0]), .done(done[0]),
        .op_count(cnt[0]), .state_o(st[0])
    );

    calc_op_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .CLOCK_50(clk), .Reset(rst), .KEY(key), .SW(sw), .ACC(acc),
        .calc_op(c_op[1]), .calc_A(c_a[1]), .calc_B(c_b[1]),
        .calc_R(c_r[1]), .calc_ovf(c_v[1]), .R_out(r_out[1]),
        .ovf_out(ovf_o[1]), .busy(busy[1]), .done(done[1]),
        .op_count(cnt[1]), .state_o(st[1])
    );

    calc_op_sequencer #(.SETTLE_CYCLES(15)) dut15 (
        .CLOCK_50(clk), .Reset(rst), .KEY(key), .SW(sw), .ACC(acc),
        .calc_op(c_op[2]), .calc_A(c_a[2]), .calc_B(c_b[2]),
        .calc_R(c_r[2]), .calc_ovf(c_v[2]), .R_out(r_out[2]),
        .ovf_out(ovf_o[2]), .busy(busy[2]), .done(done[2]),
        .op_count(cnt[2]), .state_o(st[2])
    );

    // ---------------- scoreboard ----------------
    // Entry: {R_out[3:0], ovf_out, op_count[3:0]} expected at the done pulse.
    localparam int W = 9;
    logic [W-1:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] m_cnt = 4'd0;
    logic       m_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse of the SETTLE=2 instance.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (done[0] === 1'b1) begin
            check("done_width", {31'd0, done_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done=1, expected no capture");
            end else begin
                e = exp_q.pop_front();
                check("sb_R_out", {28'd0, r_out[0]}, {28'd0, e[8:5]});
                check("sb_ovf_out", {31'd0, ovf_o[0]}, {31'd0, e[4]});
                check("sb_op_count", {28'd0, cnt[0]}, {28'd0, e[3:0]});
            end
        end
        done_prev = done[0];
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_values(input string tag);
        check({tag, "_calc_op"}, {29'd0, c_op[0]}, 32'h7);
        check({tag, "_calc_A"}, {28'd0, c_a[0]}, 32'd0);
        check({tag, "_calc_B"}, {28'd0, c_b[0]}, 32'd0);
        check({tag, "_R_out"}, {28'd0, r_out[0]}, 32'd0);
        check({tag, "_ovf"}, {31'd0, ovf_o[0]}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy[0]}, 32'd0);
        check({tag, "_done"}, {31'd0, done[0]}, 32'd0);
        check({tag, "_op_count"}, {28'd0, cnt[0]}, 32'd0);
    endtask

    task automatic reset_dut(input string tag);
        @(negedge clk);
        rst = 1'b1; key = 3'b111; sw = 8'h00; acc = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values(tag);
        m_cnt = 4'd0;
        m_ovf = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Issue one operation on the SETTLE=2 instance and follow it to IDLE.
    // extra=1 wiggles KEY[1] while the keys are still held after capture.
    task automatic issue(input logic [2:0] keys, input logic [7:0] swv,
                         input logic accv, input logic [2:0] exp_op,
                         input logic [3:0] exp_a, input logic [3:0] exp_r,
                         input logic exp_cv, input bit extra);
        int n;
        logic exp_sticky;
        @(negedge clk);
        sw = swv; acc = accv; key = keys;
        m_cnt = m_cnt + 4'd1;
        exp_sticky = accv ? (m_ovf | exp_cv) : exp_cv;
        exp_q.push_back({exp_r, exp_sticky, m_cnt});
        n = 0;
        @(negedge clk);
        while (busy[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("issue_latency", n, 2);
        check("issue_calc_op", {29'd0, c_op[0]}, {29'd0, exp_op});
        check("issue_calc_A", {28'd0, c_a[0]}, {28'd0, exp_a});
        check("issue_calc_B", {28'd0, c_b[0]}, {28'd0, swv[3:0]});
        check("issue_ovf_out", {31'd0, ovf_o[0]}, {31'd0, accv ? m_ovf : 1'b0});
        // Inputs moved mid-flight must not leak into the operation.
        sw = ~swv; acc = ~accv;
        while (done[0] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("capture_latency", n, 4);
        check("capture_calc_op_idle", {29'd0, c_op[0]}, 32'h7);
        check("capture_A_frozen", {28'd0, c_a[0]}, {28'd0, exp_a});
        if (extra) begin
            key = keys | 3'b010;
            repeat (3) @(negedge clk);
            key = keys;
            repeat (3) @(negedge clk);
            check("held_still_busy", {31'd0, busy[0]}, 32'd1);
        end
        key = 3'b111;
        n = 0;
        while (busy[0] !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("release_idle", {31'd0, busy[0]}, 32'd0);
        m_ovf = exp_sticky;
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [7:0] swv;
        logic [3:0] a;
        logic [3:0] r;
        logic       v;
    } vec_t;

    vec_t wrap_vecs[4];

    initial begin
        int n, lat1, lat15, w1, w15;
        bit bad;
        wrap_vecs[0] = '{8'h11, 4'd1, 4'd2, 1'b0};
        wrap_vecs[1] = '{8'h7f, 4'd7, 4'd6, 1'b0};
        wrap_vecs[2] = '{8'h88, 4'd8, 4'd0, 1'b1};
        wrap_vecs[3] = '{8'h25, 4'd2, 4'd7, 1'b0};

        rst = 1'b1; key = 3'b111; sw = 8'h00; acc = 1'b0;

        // 1: reset values, then a basic add
        reset_dut("t1_reset");
        issue(3'b110, 8'h32, 1'b0, 3'b110, 4'd3, 4'd5, 1'b0, 1'b0);
        check("t1_R_out_5", {28'd0, r_out[0]}, 32'd5);

        // 2: overflow, accumulate chain with sticky flag, then a fresh chain
        issue(3'b110, 8'h53, 1'b0, 3'b110, 4'd5, 4'd8, 1'b1, 1'b0);
        check("t2_ovf_set", {31'd0, ovf_o[0]}, 32'd1);
        issue(3'b110, 8'h01, 1'b1, 3'b110, 4'd8, 4'd9, 1'b0, 1'b0);
        check("t2_acc_R_9", {28'd0, r_out[0]}, 32'd9);
        check("t2_ovf_sticky", {31'd0, ovf_o[0]}, 32'd1);
        issue(3'b101, 8'h11, 1'b0, 3'b101, 4'd1, 4'd2, 1'b0, 1'b0);
        check("t2_ovf_cleared", {31'd0, ovf_o[0]}, 32'd0);

        // 3: all keys at once, KEY[0] wins; re-press while held is ignored
        issue(3'b000, 8'h21, 1'b0, 3'b110, 4'd2, 4'd3, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check("t3_single_capture", {28'd0, cnt[0]}, 32'd5);

        // 4: reset mid-ISSUE with KEY[1] held, held key is not a press
        @(negedge clk);
        sw = 8'h44; acc = 1'b0; key = 3'b101;
        n = 0;
        while (busy[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_in_issue", {31'd0, busy[0]}, 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("t4_abort");
        m_cnt = 4'd0;
        m_ovf = 1'b0;
        rst = 1'b0;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busy[0] !== 1'b0) bad = 1'b1;
        end
        check("t4_held_no_issue", {31'd0, bad}, 32'd0);
        key = 3'b111;
        repeat (4) @(negedge clk);
        issue(3'b101, 8'h44, 1'b0, 3'b101, 4'd4, 4'd8, 1'b1, 1'b0);

        // 5: fifteen more captures wrap op_count to zero
        for (int i = 0; i < 15; i++) begin
            issue(3'b011, wrap_vecs[i % 4].swv, 1'b0, 3'b011, wrap_vecs[i % 4].a,
                  wrap_vecs[i % 4].r, wrap_vecs[i % 4].v, 1'b0);
        end
        check("t5_op_count_wrap", {28'd0, cnt[0]}, 32'd0);

        // 6: SETTLE_CYCLES 1 and 15 latency and done width
        check("t6_queue_empty", exp_q.size(), 0);
        reset_dut("t6_reset");
        @(negedge clk);
        sw = 8'h12; acc = 1'b0; key = 3'b110;
        m_cnt = 4'd1;
        exp_q.push_back({4'd3, 1'b0, 4'd1});
        lat1 = -1; lat15 = -1; w1 = 0; w15 = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done[1] === 1'b1) begin
                if (lat1 < 0) lat1 = k;
                w1++;
            end
            if (done[2] === 1'b1) begin
                if (lat15 < 0) lat15 = k;
                w15++;
            end
        end
        check("t6_latency_s1", lat1, 3);
        check("t6_latency_s15", lat15, 17);
        check("t6_done_width_s1", w1, 1);
        check("t6_done_width_s15", w15, 1);
        check("t6_R_s1", {28'd0, r_out[1]}, 32'd3);
        check("t6_R_s15", {28'd0, r_out[2]}, 32'd3);
        key = 3'b111;
        n = 0;
        while ((busy[0] | busy[1] | busy[2]) !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_all_idle", {31'd0, busy[0] | busy[1] | busy[2]}, 32'd0);

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound in case a handshake never completes.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
